tt_um_hoene_manchester_encoder: RTL and testbench
=================================================

Name: tt_um_hoene_manchester_encoder

Overview:
Downstream forwarding stage of the LED daisy-chain receiver. Takes decoded bits from the Manchester decoder (data plus a one-cycle bit strobe), optionally inverts each bit (protocol swap), and buffers them in a small FIFO. It re-emits the bits as a Manchester line toward the next chip, using the half-bit width measured by the decoder. Output uses a pin on the uo_out bus.

Parameters:
FIFO_DEPTH, 8, number of buffered bits; power of two, >=2
PW_WIDTH, 6, width of the half-bit period input, in clk cycles

Ports:
clk  input  1  system clock
rst  input  1  reset
in_data  input  1  decoded bit, valid when in_clk=1
in_clk  input  1  one-cycle strobe: accept in_data this cycle
in_swap  input  1  invert the bit accepted this cycle
in_pulsewidth  input  PW_WIDTH  half-bit period in clk cycles; latched at the start of each bit
out  output  1  Manchester line
out_busy  output  1  encoder not IDLE or FIFO not empty
out_level  output  clog2(FIFO_DEPTH)+1  FIFO fill count
out_overflow  output  1  sticky: a bit was dropped because the FIFO was full

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All state changes on the rising edge of clk.
- Reset values: out=0, out_busy=0, out_level=0, out_overflow=0. FIFO pointers are 0 and the FSM is in IDLE. Reset mid-bit aborts the bit immediately; out goes to 0 on the next edge.
- Push: when in_clk=1 and the FIFO is not full, write in_data XOR in_swap.
- Pop: the FSM pops a bit when it starts a new bit.
- Push while full: the bit is dropped and out_overflow is set to 1. out_overflow is cleared only by rst.
- Push and pop in the same cycle:
  - Full FIFO: the push is accepted and the level is unchanged.
  - Empty FIFO: there is no bypass; the bit is written and the pop is deferred.
- Line coding: bit 1 = first half 0, second half 1. Bit 0 = first half 1, second half 0. Idle level is 0.
- Half-period: hp = latched in_pulsewidth, with 0 treated as 1. Each half lasts exactly hp cycles. The latched value is held constant for the whole bit.
- FSM states: IDLE, FIRST, SECOND.
  - IDLE -> FIRST when the FIFO is non-empty: pop, latch hp, reset the counter. out takes the first-half level on the same edge.
  - FIRST -> SECOND after hp cycles. out takes the second-half level.
  - SECOND -> FIRST after hp cycles if the FIFO is non-empty: pop the next bit with no gap.
  - SECOND -> IDLE after hp cycles if the FIFO is empty. out=0.
- Latency: a strobe in cycle t into an empty, idle encoder makes out show the first half from cycle t+2.
- Half counter: PW_WIDTH bits, counting 0..hp-1. No wrap beyond hp-1.
- out_busy = (state != IDLE) || (level != 0).
- in_clk high for several consecutive cycles: each cycle is a separate push.

Optional Feature:
Macro TT_UM_HOENE_ENCODER_PREAMBLE_EN.
- Defined: adds state PREAMBLE. On leaving IDLE, two 0-bits are emitted before the first popped data bit, using the hp latched at that point. The pop happens at the end of the preamble. Back-to-back bits without a return to IDLE get no preamble. Latency from strobe to the first data bit rises by 4*hp cycles.
- Not defined: no preamble; behaviour exactly as above.

Test Plan:
- Reset check: assert rst for 3 cycles mid-transmission -> out=0, out_busy=0, out_level=0, out_overflow=0 on the next edge.
- Single bit: pulsewidth=4, in_data=1, in_swap=0, one strobe -> from t+2, out=0 for 4 cycles, then 1 for 4 cycles, then 0 (IDLE); out_busy falls with it.
- Swap and back-to-back: pulsewidth=2, push 1,0,1 with in_swap=1 on the middle bit -> line 0011 0011 0011 with no gaps, 12 cycles total.
- Overflow: FIFO_DEPTH=8, encoder stalled at pulsewidth=63, push 10 bits in 10 consecutive cycles -> level peaks at 8 (one popped, so 9 accepted); out_overflow=1; 9 bits emitted in order.
- Pulsewidth change: start bit with pw=3, change to pw=5 mid-bit -> current bit halves stay at 3 cycles; next bit uses 5. pw=0 -> halves of 1 cycle.
- Preamble (macro on): pw=2, push 1 into idle -> 1100 1100 then 0011 emitted; a second bit pushed before IDLE gets no extra preamble.

Source files
------------

// File: rtl/tt_um_hoene_manchester_encoder.sv
// Manchester re-encoder: buffers decoded bits in a small FIFO and re-emits them as a Manchester line.
// Optional macro TT_UM_HOENE_ENCODER_PREAMBLE_EN prepends two 0-bits whenever the encoder leaves IDLE.

module tt_um_hoene_manchester_encoder #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned PW_WIDTH   = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_data,
  input  logic                          in_clk,
  input  logic                          in_swap,
  input  logic [PW_WIDTH-1:0]           in_pulsewidth,
  output logic                          out,
  output logic                          out_busy,
  output logic [$clog2(FIFO_DEPTH):0]   out_level,
  output logic                          out_overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {
    StIdle,
    StFirst,
    StSecond,
    StPreamble
  } state_e;

  // FIFO storage and bookkeeping
  logic [FIFO_DEPTH-1:0] mem_q;
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [LW-1:0]         level_q;
  logic                  overflow_q;

  // Line encoder state
  state_e                state_q;
  logic [PW_WIDTH-1:0]   cnt_q;
  logic [PW_WIDTH-1:0]   hp_last_q;
  logic                  bit_q;
  logic                  out_q;
`ifdef TT_UM_HOENE_ENCODER_PREAMBLE_EN
  logic [1:0]            pre_half_q;
`endif

  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  fifo_head;
  logic                  push;
  logic                  pop;
  logic                  half_done;
  logic [PW_WIDTH-1:0]   hp_last_in;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
  assign fifo_head  = mem_q[rd_ptr_q];

  // A full FIFO still accepts the write when the encoder pops in the same cycle.
  assign push = in_clk && (!fifo_full || pop);

  // Counter runs 0..hp-1; a pulsewidth of 0 behaves as 1.
  assign hp_last_in = (in_pulsewidth == '0) ? '0 : in_pulsewidth - PW_WIDTH'(1);
  assign half_done  = (cnt_q == hp_last_q);

  always_comb begin
    pop = 1'b0;
    case (state_q)
`ifdef TT_UM_HOENE_ENCODER_PREAMBLE_EN
      StIdle:     pop = 1'b0;
      StPreamble: pop = half_done && (pre_half_q == 2'd3);
`else
      StIdle:     pop = !fifo_empty;
`endif
      StSecond:   pop = half_done && !fifo_empty;
      default:    pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data ^ in_swap;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      if (in_clk && !push) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Bit 1 is sent as 0 then 1, bit 0 as 1 then 0; the line idles low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      hp_last_q  <= '0;
      bit_q      <= 1'b0;
      out_q      <= 1'b0;
`ifdef TT_UM_HOENE_ENCODER_PREAMBLE_EN
      pre_half_q <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            hp_last_q <= hp_last_in;
            cnt_q     <= '0;
`ifdef TT_UM_HOENE_ENCODER_PREAMBLE_EN
            state_q    <= StPreamble;
            pre_half_q <= '0;
            out_q      <= 1'b1;
`else
            state_q   <= StFirst;
            bit_q     <= fifo_head;
            out_q     <= ~fifo_head;
`endif
          end
        end
        StFirst: begin
          if (half_done) begin
            state_q <= StSecond;
            cnt_q   <= '0;
            out_q   <= bit_q;
          end else begin
            cnt_q <= cnt_q + PW_WIDTH'(1);
          end
        end
        StSecond: begin
          if (half_done) begin
            cnt_q <= '0;
            if (pop) begin
              state_q   <= StFirst;
              bit_q     <= fifo_head;
              hp_last_q <= hp_last_in;
              out_q     <= ~fifo_head;
            end else begin
              state_q <= StIdle;
              out_q   <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + PW_WIDTH'(1);
          end
        end
`ifdef TT_UM_HOENE_ENCODER_PREAMBLE_EN
        StPreamble: begin
          if (half_done) begin
            cnt_q <= '0;
            if (pop) begin
              state_q   <= StFirst;
              bit_q     <= fifo_head;
              hp_last_q <= hp_last_in;
              out_q     <= ~fifo_head;
            end else begin
              // Halves alternate 1,0,1,0: two Manchester 0-bits.
              pre_half_q <= pre_half_q + 2'd1;
              out_q      <= pre_half_q[0];
            end
          end else begin
            cnt_q <= cnt_q + PW_WIDTH'(1);
          end
        end
`endif
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          out_q   <= 1'b0;
        end
      endcase
    end
  end

  assign out          = out_q;
  assign out_busy     = (state_q != StIdle) || !fifo_empty;
  assign out_level    = level_q;
  assign out_overflow = overflow_q;

endmodule

// File: tb/tb_tt_um_hoene_manchester_encoder.sv
// Scoreboard bench for tt_um_hoene_manchester_encoder: stimulus queues per-cycle expected line
// samples, a negedge monitor pops and compares them.

module tb_tt_um_hoene_manchester_encoder;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PW    = 6;
`ifdef TT_UM_HOENE_ENCODER_PREAMBLE_EN
  localparam logic PRE = 1'b1;
`else
  localparam logic PRE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_data = 1'b0;
  logic          in_clk = 1'b0;
  logic          in_swap = 1'b0;
  logic [PW-1:0] in_pulsewidth = '0;
  logic          out;
  logic          out_busy;
  logic [3:0]    out_level;
  logic          out_overflow;

  tt_um_hoene_manchester_encoder #(
    .FIFO_DEPTH(DEPTH),
    .PW_WIDTH  (PW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_clk       (in_clk),
    .in_swap      (in_swap),
    .in_pulsewidth(in_pulsewidth),
    .out          (out),
    .out_busy     (out_busy),
    .out_level    (out_level),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;

  // care bits: 0 out, 1 busy, 2 level, 3 overflow
  typedef struct {
    logic       o;
    logic       b;
    int         lvl;
    logic       ov;
    logic [3:0] care;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      if (mon_e.care[0]) check("out", {31'b0, out}, {31'b0, mon_e.o});
      if (mon_e.care[1]) check("out_busy", {31'b0, out_busy}, {31'b0, mon_e.b});
      if (mon_e.care[2]) check("out_level", {28'b0, out_level}, mon_e.lvl);
      if (mon_e.care[3]) check("out_overflow", {31'b0, out_overflow}, {31'b0, mon_e.ov});
    end
  end

  task automatic q_s(input logic o, input logic b, input int lvl, input logic ov,
                     input logic [3:0] care);
    exp_t e;
    e.o = o; e.b = b; e.lvl = lvl; e.ov = ov; e.care = care;
    exp_q.push_back(e);
  endtask

  task automatic q_half(input logic v, input int n);
    repeat (n) q_s(v, 1'b1, 0, 1'b0, 4'b0011);
  endtask

  task automatic q_bit(input logic v, input int hp);
    q_half(~v, hp);
    q_half(v, hp);
  endtask

  task automatic q_pre(input int hp);
    if (PRE) begin
      q_bit(1'b0, hp);
      q_bit(1'b0, hp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic d, input logic s);
    in_data = d;
    in_swap = s;
    in_clk  = 1'b1;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expected samples left after %0d cycles", exp_q.size(), limit);
      exp_q.delete();
    end
  endtask

  logic d10[10];

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    d10 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    // Power-on reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    q_s(1'b0, 1'b0, 0, 1'b0, 4'hF);
    q_s(1'b0, 1'b0, 0, 1'b0, 4'hF);
    drain(10);

    // Single bit 1, pw=4
    cyc();
    in_pulsewidth = 6'd4;
    strobe(1'b1, 1'b0);
    q_s(1'b0, 1'b0, 0, 1'b0, 4'b0111);
    q_s(1'b0, 1'b1, 1, 1'b0, 4'b0111);
    q_pre(4);
    q_bit(1'b1, 4);
    q_s(1'b0, 1'b0, 0, 1'b0, 4'b0111);
    cyc();
    in_clk = 1'b0;
    drain(200);

    // Back-to-back 1,0(swapped),1 at pw=2: three 0011 symbols
    cyc();
    in_pulsewidth = 6'd2;
    strobe(1'b1, 1'b0);
    q_s(1'b0, 1'b0, 0, 1'b0, 4'b0111);
    q_s(1'b0, 1'b1, 1, 1'b0, 4'b0111);
    q_pre(2);
    q_bit(1'b1, 2);
    q_bit(1'b1, 2);
    q_bit(1'b1, 2);
    q_s(1'b0, 1'b0, 0, 1'b0, 4'b0111);
    cyc();
    strobe(1'b0, 1'b1);
    cyc();
    strobe(1'b1, 1'b0);
    cyc();
    in_clk  = 1'b0;
    in_swap = 1'b0;
    drain(200);

    // pw 3 -> 5 change mid-bit: current bit keeps 3, next bit uses 5
    cyc();
    in_pulsewidth = 6'd3;
    strobe(1'b0, 1'b0);
    q_s(1'b0, 1'b0, 0, 1'b0, 4'b0111);
    q_s(1'b0, 1'b1, 1, 1'b0, 4'b0111);
    q_pre(3);
    q_bit(1'b0, 3);
    q_bit(1'b1, 5);
    q_s(1'b0, 1'b0, 0, 1'b0, 4'b0111);
    cyc();
    in_clk = 1'b0;
    repeat (2 + (PRE ? 12 : 0)) cyc();
    in_pulsewidth = 6'd5;
    strobe(1'b1, 1'b0);
    cyc();
    in_clk = 1'b0;
    drain(200);

    // pw=0 behaves as 1-cycle halves
    cyc();
    in_pulsewidth = 6'd0;
    strobe(1'b0, 1'b0);
    q_s(1'b0, 1'b0, 0, 1'b0, 4'b0111);
    q_s(1'b0, 1'b1, 1, 1'b0, 4'b0111);
    q_pre(1);
    q_bit(1'b0, 1);
    q_s(1'b0, 1'b0, 0, 1'b0, 4'b0111);
    cyc();
    in_clk = 1'b0;
    drain(100);

    // Overflow: 10 pushes into a stalled encoder at pw=63
    cyc();
    in_pulsewidth = 6'd63;
    q_s(1'b0, 1'b0, 0, 1'b0, 4'hF);
    q_s(1'b0, 1'b1, 1, 1'b0, 4'hF);
    for (int k = 0; k < 9; k++) begin
      if (PRE) q_s(1'b1, 1'b1, (k < 6) ? k + 2 : 8, k >= 7, 4'hF);
      else     q_s(1'b0, 1'b1, (k < 8) ? k + 1 : 8, k == 8, 4'hF);
    end
    if (PRE) begin
      q_half(1'b1, 54);
      q_half(1'b0, 63);
      q_bit(1'b0, 63);
      for (int i = 0; i < 8; i++) q_bit(d10[i], 63);
    end else begin
      q_half(1'b0, 54);
      q_half(1'b1, 63);
      for (int i = 1; i < 9; i++) q_bit(d10[i], 63);
    end
    q_s(1'b0, 1'b0, 0, 1'b1, 4'hF);
    for (int i = 0; i < 10; i++) begin
      strobe(d10[i], 1'b0);
      cyc();
    end
    in_clk = 1'b0;
    drain(3000);

    // Reset mid-transmission clears everything including sticky overflow
    cyc();
    in_pulsewidth = 6'd4;
    strobe(1'b1, 1'b0);
    q_s(1'b0, 1'b0, 0, 1'b1, 4'hF);
    q_s(1'b0, 1'b1, 1, 1'b1, 4'hF);
    repeat (3) q_s(PRE, 1'b1, 0, 1'b1, 4'b1011);
    repeat (4) q_s(1'b0, 1'b0, 0, 1'b0, 4'hF);
    cyc();
    in_clk = 1'b0;
    cyc();
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    cyc();
    cyc();
    rst = 1'b0;
    drain(50);

`ifdef TT_UM_HOENE_ENCODER_PREAMBLE_EN
    // Second bit pushed before returning to IDLE gets no extra preamble
    cyc();
    in_pulsewidth = 6'd2;
    strobe(1'b1, 1'b0);
    q_s(1'b0, 1'b0, 0, 1'b0, 4'b0111);
    q_s(1'b0, 1'b1, 1, 1'b0, 4'b0111);
    q_bit(1'b0, 2);
    q_bit(1'b0, 2);
    q_bit(1'b1, 2);
    q_bit(1'b1, 2);
    q_s(1'b0, 1'b0, 0, 1'b0, 4'b0111);
    cyc();
    in_clk = 1'b0;
    repeat (10) cyc();
    strobe(1'b1, 1'b0);
    cyc();
    in_clk = 1'b0;
    drain(100);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
